// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative divider.
//   DIV_WIDTH  default operand/result width
//   DIV_CNT_W  iteration counter width for DIV_WIDTH
//   divState_t FSM state encoding (IDLE -> BUSY -> DONE -> IDLE)
package div_unit_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } divState_t;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one combinational radix-2 restoring iteration on unsigned magnitudes.
//   rem      in   WIDTH  partial remainder (always < divisor)
//   quo      in   WIDTH  dividend bits not yet consumed / quotient bits produced
//   divisor  in   WIDTH  divisor magnitude
//   remNext  out  WIDTH  remainder after this step
//   quoNext  out  WIDTH  quotient after this step (new bit in LSB)
module div_step
   import div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remNext,
   output logic [WIDTH-1:0] quoNext
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           borrow;

   // Because rem < divisor, shifted < 2*divisor, so a WIDTH+1 bit trial is
   // enough: its MSB is set exactly when shifted < divisor.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      borrow  = trial[WIDTH];
      remNext = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], ~borrow};
   end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in EX.
//   clk         in   1      rising-edge clock
//   resetn      in   1      asynchronous active-low reset
//   startE      in   1      DIV/DIVU in EX, held while stalled
//   signedE     in   1      1 = signed (DIV), 0 = unsigned (DIVU)
//   annulE      in   1      flush; cancels any divide in flight
//   srcaE       in   WIDTH  dividend
//   srcbE       in   WIDTH  divisor
//   stall_divE  out  1      divide not complete; freeze F/D/E
//   div_readyE  out  1      one-cycle pulse, hi_divE/lo_divE valid
//   hi_divE     out  WIDTH  remainder (holds until next completion)
//   lo_divE     out  WIDTH  quotient  (holds until next completion)
module div_unit
   import div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             startE,
   input  logic             signedE,
   input  logic             annulE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   output logic             stall_divE,
   output logic             div_readyE,
   output logic [WIDTH-1:0] hi_divE,
   output logic [WIDTH-1:0] lo_divE
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   divState_t        state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divisor;
   logic             qNeg;
   logic             rNeg;

   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] quoNext;
   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH-1:0] loFinal;
   logic [WIDTH-1:0] hiFinal;
   logic             accept;
   logic             lastStep;

   div_step #(.WIDTH(WIDTH)) uStep (
      .rem     (rem),
      .quo     (quo),
      .divisor (divisor),
      .remNext (remNext),
      .quoNext (quoNext)
   );

   always_comb begin
      absA     = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
      absB     = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;
      accept   = (state == DIV_IDLE) && startE && !annulE;
      lastStep = (state == DIV_BUSY) && (count == CNT_W'(WIDTH - 1));
      loFinal  = qNeg ? -quoNext : quoNext;
      hiFinal  = rNeg ? -remNext : remNext;
      // Stall is combinational so the first EX cycle of a divide already
      // freezes the pipe; annul and reset release it in the same cycle.
      stall_divE = resetn && (accept || ((state == DIV_BUSY) && !annulE));
      div_readyE = (state == DIV_DONE) && !annulE;
   end

   // Sign-corrected results are registered on the final step so they are
   // valid throughout DONE and hold afterwards.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= DIV_IDLE;
         count   <= '0;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         qNeg    <= 1'b0;
         rNeg    <= 1'b0;
         hi_divE <= '0;
         lo_divE <= '0;
      end else if (annulE) begin
         state <= DIV_IDLE;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (startE) begin
                  state   <= DIV_BUSY;
                  count   <= '0;
                  rem     <= '0;
                  quo     <= absA;
                  divisor <= absB;
                  qNeg    <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                  rNeg    <= signedE & srcaE[WIDTH-1];
               end
            end
            DIV_BUSY: begin
               rem   <= remNext;
               quo   <= quoNext;
               count <= count + 1'b1;
               if (lastStep) begin
                  state   <= DIV_DONE;
                  hi_divE <= hiFinal;
                  lo_divE <= loFinal;
               end
            end
            DIV_DONE: state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         startE = 1'b0;
   logic         signedE = 1'b0;
   logic         annulE = 1'b0;
   logic [W-1:0] srcaE = '0;
   logic [W-1:0] srcbE = '0;
   logic         stall_divE;
   logic         div_readyE;
   logic [W-1:0] hi_divE;
   logic [W-1:0] lo_divE;

   div_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .startE     (startE),
      .signedE    (signedE),
      .annulE     (annulE),
      .srcaE      (srcaE),
      .srcbE      (srcbE),
      .stall_divE (stall_divE),
      .div_readyE (div_readyE),
      .hi_divE    (hi_divE),
      .lo_divE    (lo_divE)
   );

   always #5 clk = ~clk;

   logic [63:0] sbQ[$];
   logic [63:0] monExp;
   int          nVec = 0;
   int          nMis = 0;
   int          readyCnt = 0;
   int          expReady = 0;

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nVec++;
      if (obs !== exp) begin
         nMis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected {hi, lo}: plain SV arithmetic plus the documented special cases.
   function automatic logic [63:0] refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      int sa;
      int sb;
      int q;
      int r;
      if (!sgn) begin
         if (b == 0) return {a, 32'hFFFF_FFFF};
         return {a % b, a / b};
      end
      if (b == 0) return {a, (a[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
      return {32'(r), 32'(q)};
   endfunction

   // Scoreboard consumer: every ready pulse must match the oldest pending divide.
   always @(posedge clk) begin
      #3;
      if (div_readyE === 1'b1) begin
         readyCnt++;
         if (sbQ.size() == 0) begin
            checkEq("spuriousReady", 64'(div_readyE), 64'd0);
         end else begin
            monExp = sbQ.pop_front();
            checkEq("lo", 64'(lo_divE), 64'(monExp[31:0]));
            checkEq("hi", 64'(hi_divE), 64'(monExp[63:32]));
         end
      end
   end

   // Called at posedge+1; returns at posedge+2 of the accept cycle.
   task automatic startDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      srcaE   = a;
      srcbE   = b;
      signedE = sgn;
      startE  = 1'b1;
      sbQ.push_back(refDiv(a, b, sgn));
      expReady++;
      #1;
      checkEq("stallOnStart", 64'(stall_divE), 64'd1);
   endtask

   // Counts stall cycles including the accept cycle; returns at posedge+2 of DONE.
   task automatic waitDone();
      int n = 1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2;
         if (!stall_divE) break;
         n++;
      end
      checkEq("stallCycles", 64'(n), 64'd33);
      checkEq("readyAfterStall", 64'(div_readyE), 64'd1);
   endtask

   task automatic runDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      @(posedge clk);
      #1;
      startDiv(a, b, sgn);
      waitDone();
      startE = 1'b0;
   endtask

   logic [W-1:0] tA[10] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd5,
                            32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
   logic [W-1:0] tB[10] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,
                            32'd0, 32'd0, 32'd1, 32'd2, 32'd5};
   logic         tS[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                            1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   initial begin
      // Reset state, with startE high to show reset masks the stall.
      startE = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkEq("rstStall", 64'(stall_divE), 64'd0);
      checkEq("rstReady", 64'(div_readyE), 64'd0);
      checkEq("rstHi", 64'(hi_divE), 64'd0);
      checkEq("rstLo", 64'(lo_divE), 64'd0);
      startE = 1'b0;
      resetn = 1'b1;

      for (int i = 0; i < 10; i++) runDiv(tA[i], tB[i], tS[i]);

      // Results hold after the ready pulse.
      runDiv(32'd100, 32'd7, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checkEq("loHold", 64'(lo_divE), 64'd14);
      checkEq("hiHold", 64'(hi_divE), 64'd2);

      for (int i = 0; i < 6; i++) runDiv($urandom, $urandom_range(1, 5000), 1'($urandom_range(0, 1)));

      // Annul at BUSY cycle 10, then a new divide the following cycle.
      @(posedge clk);
      #1;
      startDiv(32'd1000, 32'd3, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      annulE = 1'b1;
      #1;
      checkEq("annulStall", 64'(stall_divE), 64'd0);
      checkEq("annulReady", 64'(div_readyE), 64'd0);
      void'(sbQ.pop_back());
      expReady--;
      @(posedge clk);
      #1;
      annulE = 1'b0;
      startDiv(32'd9, 32'd3, 1'b0);
      waitDone();
      startE = 1'b0;

      // Back-to-back with startE held through DONE.
      @(posedge clk);
      #1;
      startDiv(32'd1000, 32'd7, 1'b0);
      waitDone();
      srcaE   = 32'hFFFF_FF9C;
      srcbE   = 32'd9;
      signedE = 1'b1;
      #1;
      checkEq("b2bGap", 64'(stall_divE), 64'd0);
      @(posedge clk);
      #1;
      startDiv(32'hFFFF_FF9C, 32'd9, 1'b1);
      waitDone();
      startE = 1'b0;

      // Reset in the middle of BUSY.
      @(posedge clk);
      #1;
      startDiv(32'd1234, 32'd5, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      checkEq("midRstStall", 64'(stall_divE), 64'd0);
      checkEq("midRstReady", 64'(div_readyE), 64'd0);
      checkEq("midRstHi", 64'(hi_divE), 64'd0);
      checkEq("midRstLo", 64'(lo_divE), 64'd0);
      void'(sbQ.pop_back());
      expReady--;
      startE = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;

      repeat (40) @(posedge clk);
      #4;
      checkEq("readyCount", 64'(readyCnt), 64'(expReady));
      checkEq("sbEmpty", 64'(sbQ.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
